// File: rtl/serializer_stream_if.sv
// Handshake bundle for serializer_stream: the parallel word input with its
// valid/ready pair, the serial bit output with its valid/ready pair, the
// busy flag and a debug view of the FSM state.
//
// Valid/ready rule used on both sides: a transfer happens on a rising clock
// edge where valid and ready are both 1. The producer holds its valid and
// payload stable until that edge. The consumer may change ready freely.
interface serializer_stream_if #(
  parameter int DATA_W = 16
) ();
  localparam int MOD_W = $clog2(DATA_W);

  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ready_o;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              ser_ready_i;
  logic              busy_o;
  logic [1:0]        dbg_state;

  // Serializer side.
  modport slave (
    input  data_i,
    input  data_mod_i,
    input  data_val_i,
    input  ser_ready_i,
    output ready_o,
    output ser_data_o,
    output ser_data_val_o,
    output busy_o,
    output dbg_state
  );

  // Source / sink side.
  modport master (
    output data_i,
    output data_mod_i,
    output data_val_i,
    output ser_ready_i,
    input  ready_o,
    input  ser_data_o,
    input  ser_data_val_o,
    input  busy_o,
    input  dbg_state
  );
endinterface

// File: rtl/serializer_stream.sv
// Parallel-to-serial converter with a programmable length per word,
// selectable bit order, a one-word input buffer, and backpressure from the
// serial sink.
//
// Storage is one shift stage (the word being sent) and one buffer slot.
// The FSM state encodes which of the two are occupied:
//   ST_IDLE       shift stage empty, buffer empty
//   ST_SHIFT      shift stage active, buffer empty
//   ST_SHIFT_FULL shift stage active, buffer full
// ready_o is the registered inverse of buffer occupancy. Words whose
// decoded length is below MIN_LEN complete the handshake but are dropped.
// When the last bit transfers, the buffered word (or a word accepted on that
// same edge) loads straight into the shift stage, so consecutive words go
// out back to back with no gap.
module serializer_stream #(
  parameter int DATA_W    = 16,
  parameter int MIN_LEN   = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk_i,
  input  logic                srst_i,
  serializer_stream_if.slave  bus
);

  localparam int MOD_W = $clog2(DATA_W);
  // Wide enough to hold DATA_W itself.
  localparam int LEN_W = MOD_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT      = 2'd1,
    ST_SHIFT_FULL = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;     // bits still to be sent, next one at the head
  logic [LEN_W-1:0]  r_cnt;       // bits still to be sent after the one on ser_data_o
  logic [DATA_W-1:0] r_buf_data;
  logic [LEN_W-1:0]  r_buf_len;
  logic              r_ser_data;
  logic              r_ser_val;
  logic              r_busy;
  logic              r_ready;

  logic [LEN_W-1:0]  w_in_len;
  logic              w_in_legal;
  logic              w_accept;
  logic              w_xfer;
  logic              w_last;
  logic              w_in_first;
  logic [DATA_W-1:0] w_in_rest;
  logic              w_buf_first;
  logic [DATA_W-1:0] w_buf_rest;
  logic              w_adv_bit;
  logic [DATA_W-1:0] w_adv_rest;

  // Bit at the head of a word in the configured transmit order.
  function automatic logic head_bit(input logic [DATA_W-1:0] d);
    if (MSB_FIRST != 0) return d[DATA_W-1];
    else                return d[0];
  endfunction

  // Word with its head bit removed, the next bit moved to the head.
  function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] d);
    if (MSB_FIRST != 0) return d << 1;
    else                return d >> 1;
  endfunction

  // Length decode: a modifier of zero means a full-width word.
  assign w_in_len   = (bus.data_mod_i == '0) ? LEN_W'(DATA_W) : {1'b0, bus.data_mod_i};
  assign w_in_legal = (w_in_len >= LEN_W'(MIN_LEN));

  // Handshakes. Reset priority in the FSM block makes any accept on a reset
  // edge a no-op.
  assign w_accept = bus.data_val_i && r_ready;
  assign w_xfer   = r_ser_val && bus.ser_ready_i;
  assign w_last   = w_xfer && (r_cnt == '0);

  // First bit and remainder for each source that can load the shift stage.
  assign w_in_first  = head_bit(bus.data_i);
  assign w_in_rest   = drop_head(bus.data_i);
  assign w_buf_first = head_bit(r_buf_data);
  assign w_buf_rest  = drop_head(r_buf_data);
  assign w_adv_bit   = head_bit(r_shift);
  assign w_adv_rest  = drop_head(r_shift);

  // Occupancy FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_buf_data <= '0;
      r_buf_len  <= '0;
      r_ser_data <= 1'b0;
      r_ser_val  <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_in_legal) begin
            r_ser_data <= w_in_first;
            r_shift    <= w_in_rest;
            r_cnt      <= w_in_len - LEN_W'(1);
            r_ser_val  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_last) begin
            if (w_accept && w_in_legal) begin
              // Same-edge accept goes straight to the shift stage.
              r_ser_data <= w_in_first;
              r_shift    <= w_in_rest;
              r_cnt      <= w_in_len - LEN_W'(1);
            end else begin
              r_ser_data <= 1'b0;
              r_ser_val  <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end else begin
            if (w_xfer) begin
              r_ser_data <= w_adv_bit;
              r_shift    <= w_adv_rest;
              r_cnt      <= r_cnt - LEN_W'(1);
            end
            if (w_accept && w_in_legal) begin
              r_buf_data <= bus.data_i;
              r_buf_len  <= w_in_len;
              r_ready    <= 1'b0;
              r_state    <= ST_SHIFT_FULL;
            end
          end
        end

        ST_SHIFT_FULL: begin
          if (w_last) begin
            // Hand-over: buffered word starts on the next cycle, no bubble.
            r_ser_data <= w_buf_first;
            r_shift    <= w_buf_rest;
            r_cnt      <= r_buf_len - LEN_W'(1);
            r_ready    <= 1'b1;
            r_state    <= ST_SHIFT;
          end else if (w_xfer) begin
            r_ser_data <= w_adv_bit;
            r_shift    <= w_adv_rest;
            r_cnt      <= r_cnt - LEN_W'(1);
          end
        end

        default: begin
          r_ser_val <= 1'b0;
          r_busy    <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o        = r_ready;
  assign bus.ser_data_o     = r_ser_data;
  assign bus.ser_data_val_o = r_ser_val;
  assign bus.busy_o         = r_busy;
  assign bus.dbg_state      = r_state;

endmodule
